squat_anim_seq: RTL and testbench

Frame-synchronous animation sequencer for the VGA squat demo. It drives the frame-select input of the video generator, stepping through the squat pose frames: descend, hold at the bottom, ascend, hold at the top. It runs for a requested number of repetitions. It sits in `vga` between `vgaController` (x/y counters) and `videoGen`. It replaces the raw `frame_switch` pin, and all frame changes land inside vertical blanking so no frame tears.

---
 rtl/squat_pkg.sv | 41 ++++
 rtl/squat_anim_seq_frame_tick_gen.sv | 38 +++
 rtl/squat_anim_seq.sv | 214 +++++++++++++++++++++
 tb/tb_squat_anim_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/squat_pkg.sv
// Shared types and constants for the squat animation and its display-side consumers.
// Contents: anim_state_t (the phase encoding), raster defaults, the phase width,
// rectangle/line primitives for videoGen, and a small max helper used for counter sizing.
package squat_pkg;

  localparam int unsigned HACTIVE_DEF  = 640;
  localparam int unsigned VACTIVE_DEF  = 480;
  localparam int unsigned ANIM_PHASE_W = 3;

  // Phase values are visible on the phase output and shared with scoreboard logic.
  typedef enum logic [ANIM_PHASE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_DESCEND  = 3'd1,
    ST_HOLD_BOT = 3'd2,
    ST_ASCEND   = 3'd3,
    ST_HOLD_TOP = 3'd4
  } anim_state_t;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
  } rect_t;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
  } line_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/squat_anim_seq_frame_tick_gen.sv
// frame_tick_gen: detects the first pixel of vertical blanking and emits a registered
// one-cycle tick on the following cycle.
// Ports:
//   i_clk  - pixel clock
//   i_rst  - asynchronous active-high reset
//   i_x    - current pixel column
//   i_y    - current pixel row
//   o_tick - one-cycle pulse, the cycle after x==0 && y==VACTIVE is sampled
module frame_tick_gen
  import squat_pkg::*;
#(
  parameter int unsigned HACTIVE = HACTIVE_DEF,
  parameter int unsigned VACTIVE = VACTIVE_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_tick
);

  // A raster that does not fit the 10-bit counters can never reach blank start.
  localparam bit GEOM_OK = (HACTIVE <= 1024) && (VACTIVE < 1024);

  logic w_blank_start;

  assign w_blank_start = GEOM_OK && (i_x == 10'd0) && (i_y == 10'(VACTIVE));

  // Registered tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tick <= 1'b0;
    end else begin
      o_tick <= w_blank_start;
    end
  end

endmodule

// File: rtl/squat_anim_seq.sv
// squat_anim_seq: frame-synchronous squat pose sequencer driving videoGen's frame select.
// Cycles descend -> hold bottom -> ascend -> hold top for a requested number of reps;
// all state and frame_idx changes happen on frame_tick so they land in vertical blanking.
// Optional feature macro: SQUAT_PAUSE_EN adds the pause input (freezes animation at ticks).
// Ports:
//   vgaclk, reset     - pixel clock, asynchronous active-high reset
//   x, y              - raster position from vgaController
//   start, abort      - one-cycle requests, may arrive on any cycle
//   pause             - level freeze (SQUAT_PAUSE_EN only)
//   rep_target        - reps to perform, latched on an accepted start
//   frame_idx         - pose frame select (0 = standing, NFRAMES-1 = bottom)
//   phase             - anim_state_t encoding
//   rep_count         - completed reps (saturating)
//   busy, done        - not-idle level, set-complete pulse
//   frame_tick        - one-cycle pulse per video frame
module squat_anim_seq
  import squat_pkg::*;
#(
  parameter int unsigned NFRAMES     = 4,
  parameter int unsigned HOLD_FRAMES = 15,
  parameter int unsigned BOTTOM_HOLD = 30,
  parameter int unsigned TOP_HOLD    = 30,
  parameter int unsigned HACTIVE     = HACTIVE_DEF,
  parameter int unsigned VACTIVE     = VACTIVE_DEF,
  parameter int unsigned REP_W       = 8
) (
  input  logic                       vgaclk,
  input  logic                       reset,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  input  logic                       start,
  input  logic                       abort,
`ifdef SQUAT_PAUSE_EN
  input  logic                       pause,
`endif
  input  logic [REP_W-1:0]           rep_target,
  output logic [$clog2(NFRAMES)-1:0] frame_idx,
  output logic [ANIM_PHASE_W-1:0]    phase,
  output logic [REP_W-1:0]           rep_count,
  output logic                       busy,
  output logic                       done,
  output logic                       frame_tick
);

  localparam int unsigned FRAME_W  = $clog2(NFRAMES);
  localparam int unsigned HCNT_RAW = $clog2(max3(HOLD_FRAMES, BOTTOM_HOLD, TOP_HOLD));
  localparam int unsigned HCNT_W   = (HCNT_RAW == 0) ? 1 : HCNT_RAW;

  anim_state_t        r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic [HCNT_W-1:0]  r_hcnt, w_hcnt_nxt;
  logic [REP_W-1:0]   r_rep, w_rep_nxt;
  logic [REP_W-1:0]   r_target, w_target_nxt;
  logic               r_start_pend, w_start_pend_nxt;
  logic               r_abort_pend, w_abort_pend_nxt;
  logic               r_done, w_done_nxt;
  logic               r_busy;

  logic               w_tick;
  logic               w_abort;
  logic               w_start_acc;
  logic               w_paused;
  logic [FRAME_W-1:0] w_frame_inc;
  logic [FRAME_W-1:0] w_frame_dec;
  logic [REP_W-1:0]   w_rep_sat;

  frame_tick_gen #(
    .HACTIVE (HACTIVE),
    .VACTIVE (VACTIVE)
  ) u_frame_tick_gen (
    .i_clk  (vgaclk),
    .i_rst  (reset),
    .i_x    (x),
    .i_y    (y),
    .o_tick (w_tick)
  );

`ifdef SQUAT_PAUSE_EN
  assign w_paused = pause;
`else
  assign w_paused = 1'b0;
`endif

  // A request on the tick cycle itself is acted on at that tick.
  assign w_abort     = abort | r_abort_pend;
  assign w_start_acc = start && (r_state == ST_IDLE) && (rep_target != '0) && !w_abort;
  assign w_frame_inc = r_frame + FRAME_W'(1);
  assign w_frame_dec = r_frame - FRAME_W'(1);
  assign w_rep_sat   = (r_rep == '1) ? r_rep : r_rep + REP_W'(1);

  // State and datapath registers.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_frame      <= '0;
      r_hcnt       <= '0;
      r_rep        <= '0;
      r_target     <= '0;
      r_start_pend <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame      <= w_frame_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_rep        <= w_rep_nxt;
      r_target     <= w_target_nxt;
      r_start_pend <= w_start_pend_nxt;
      r_abort_pend <= w_abort_pend_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and datapath logic; nothing but the pending flags moves off-tick.
  always_comb begin
    w_state_nxt      = r_state;
    w_frame_nxt      = r_frame;
    w_hcnt_nxt       = r_hcnt;
    w_rep_nxt        = r_rep;
    w_target_nxt     = r_target;
    w_start_pend_nxt = r_start_pend;
    w_abort_pend_nxt = r_abort_pend | abort;
    w_done_nxt       = 1'b0;

    if (w_start_acc) begin
      w_start_pend_nxt = 1'b1;
      w_target_nxt     = rep_target;
    end
    if (w_abort) begin
      w_start_pend_nxt = 1'b0;
    end

    if (w_tick) begin
      w_abort_pend_nxt = 1'b0;
      if (w_abort) begin
        // Abort beats start and a completing rep; rep_count is left as is.
        w_state_nxt = ST_IDLE;
        w_frame_nxt = '0;
        w_hcnt_nxt  = '0;
      end else if (!w_paused) begin
        case (r_state)
          ST_IDLE: begin
            if (r_start_pend || w_start_acc) begin
              w_state_nxt      = ST_DESCEND;
              w_frame_nxt      = '0;
              w_hcnt_nxt       = '0;
              w_rep_nxt        = '0;
              w_start_pend_nxt = 1'b0;
            end
          end
          ST_DESCEND: begin
            if (r_hcnt == HCNT_W'(HOLD_FRAMES - 1)) begin
              w_hcnt_nxt  = '0;
              w_frame_nxt = w_frame_inc;
              if (w_frame_inc == FRAME_W'(NFRAMES - 1)) begin
                w_state_nxt = ST_HOLD_BOT;
              end
            end else begin
              w_hcnt_nxt = r_hcnt + HCNT_W'(1);
            end
          end
          ST_HOLD_BOT: begin
            if (r_hcnt == HCNT_W'(BOTTOM_HOLD - 1)) begin
              w_state_nxt = ST_ASCEND;
              w_hcnt_nxt  = '0;
            end else begin
              w_hcnt_nxt = r_hcnt + HCNT_W'(1);
            end
          end
          ST_ASCEND: begin
            if (r_hcnt == HCNT_W'(HOLD_FRAMES - 1)) begin
              w_hcnt_nxt  = '0;
              w_frame_nxt = w_frame_dec;
              if (w_frame_dec == '0) begin
                w_rep_nxt = w_rep_sat;
                if (w_rep_sat == r_target) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
                end else begin
                  w_state_nxt = ST_HOLD_TOP;
                end
              end
            end else begin
              w_hcnt_nxt = r_hcnt + HCNT_W'(1);
            end
          end
          ST_HOLD_TOP: begin
            if (r_hcnt == HCNT_W'(TOP_HOLD - 1)) begin
              w_state_nxt = ST_DESCEND;
              w_hcnt_nxt  = '0;
            end else begin
              w_hcnt_nxt = r_hcnt + HCNT_W'(1);
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_frame_nxt = '0;
            w_hcnt_nxt  = '0;
          end
        endcase
      end
    end
  end

  assign frame_idx  = r_frame;
  assign phase      = r_state;
  assign rep_count  = r_rep;
  assign busy       = r_busy;
  assign done       = r_done;
  assign frame_tick = w_tick;

endmodule

// File: tb/tb_squat_anim_seq.sv
// Directed bench for squat_anim_seq on a compressed 6x5 raster (VACTIVE=3).
module tb_squat_anim_seq;

  localparam int unsigned XN   = 6;
  localparam int unsigned YN   = 5;
  localparam int unsigned VACT = 3;

  logic       vgaclk;
  logic       reset;
  logic [9:0] x;
  logic [9:0] y;
  logic       start;
  logic       abort;
`ifdef SQUAT_PAUSE_EN
  logic       pause;
`endif
  logic [7:0] rep_target;
  logic [1:0] frame_idx;
  logic [2:0] phase;
  logic [7:0] rep_count;
  logic       busy;
  logic       done;
  logic       frame_tick;

  int checks;
  int failures;
  logic [1:0] prev_frame;

  // Expected frame_idx / phase after each tick of a rep, t = 0 is the entry tick.
  int exp_f [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 2, 2, 1, 1, 0};
  int exp_p [16] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 0};

  squat_anim_seq #(
    .NFRAMES     (4),
    .HOLD_FRAMES (2),
    .BOTTOM_HOLD (3),
    .TOP_HOLD    (1),
    .HACTIVE     (4),
    .VACTIVE     (VACT),
    .REP_W       (8)
  ) dut (
    .vgaclk     (vgaclk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .start      (start),
    .abort      (abort),
`ifdef SQUAT_PAUSE_EN
    .pause      (pause),
`endif
    .rep_target (rep_target),
    .frame_idx  (frame_idx),
    .phase      (phase),
    .rep_count  (rep_count),
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: advance the raster and verify any frame change came out of blanking.
  task automatic cyc();
    logic [9:0] py;
    @(posedge vgaclk);
    py = y;
    #1;
    if (x == 10'(XN - 1)) begin
      x = 10'd0;
      y = (y == 10'(YN - 1)) ? 10'd0 : y + 10'd1;
    end else begin
      x = x + 10'd1;
    end
    if (frame_idx !== prev_frame && reset === 1'b0) begin
      check("frame_in_vblank", {31'd0, (py >= 10'(VACT))}, 32'd1);
    end
    prev_frame = frame_idx;
  endtask

  task automatic wait_tick_cycle();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    if (frame_tick !== 1'b1) check("tick_timeout", {31'd0, frame_tick}, 32'd1);
  endtask

  // Returns one cycle after the next tick, when that tick's update is visible.
  task automatic tick_update();
    wait_tick_cycle();
    cyc();
  endtask

  task automatic pulse_start(input logic [7:0] tgt);
    rep_target = tgt;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    vgaclk = 1'b0;
    reset = 1'b1;
    x = 10'd0;
    y = 10'd0;
    start = 1'b0;
    abort = 1'b0;
`ifdef SQUAT_PAUSE_EN
    pause = 1'b0;
`endif
    rep_target = 8'd0;
    prev_frame = 2'd0;

    repeat (3) cyc();
    check("rst_phase", 32'(phase), 0);
    check("rst_frame", 32'(frame_idx), 0);
    check("rst_rep", 32'(rep_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tick", 32'(frame_tick), 0);
    reset = 1'b0;
    cyc();

    // One rep; a start while busy (tick 3) must not change the target.
    pulse_start(8'd1);
    for (int t = 0; t < 16; t++) begin
      tick_update();
      check($sformatf("r1_frame_t%0d", t), 32'(frame_idx), exp_f[t]);
      check($sformatf("r1_phase_t%0d", t), 32'(phase), exp_p[t]);
      check($sformatf("r1_done_t%0d", t), 32'(done), (t == 15) ? 1 : 0);
      check($sformatf("r1_busy_t%0d", t), 32'(busy), (t == 15) ? 0 : 1);
      if (t == 3) pulse_start(8'd5);
    end
    check("r1_rep", 32'(rep_count), 1);
    cyc();
    check("r1_done_one_cycle", 32'(done), 0);

    // Two reps with a single HOLD_TOP tick between them.
    pulse_start(8'd2);
    for (int t = 0; t < 32; t++) begin
      tick_update();
      check($sformatf("r2_frame_t%0d", t), 32'(frame_idx), exp_f[t % 16]);
      check($sformatf("r2_phase_t%0d", t), 32'(phase), (t == 15) ? 4 : exp_p[t % 16]);
      check($sformatf("r2_done_t%0d", t), 32'(done), (t == 31) ? 1 : 0);
      if (t == 15) check("r2_rep_mid", 32'(rep_count), 1);
    end
    check("r2_rep", 32'(rep_count), 2);
    check("r2_busy", 32'(busy), 0);

    // Zero target is ignored.
    pulse_start(8'd0);
    tick_update();
    check("z_busy", 32'(busy), 0);
    check("z_phase", 32'(phase), 0);
    check("z_rep", 32'(rep_count), 2);

    // Start on the tick cycle, then abort during HOLD_BOT.
    wait_tick_cycle();
    pulse_start(8'd3);
    check("st_phase", 32'(phase), 1);
    check("st_frame", 32'(frame_idx), 0);
    check("st_rep", 32'(rep_count), 0);
    check("st_busy", 32'(busy), 1);
    repeat (8) tick_update();
    check("ab_pre_phase", 32'(phase), 2);
    check("ab_pre_frame", 32'(frame_idx), 3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    tick_update();
    check("ab_phase", 32'(phase), 0);
    check("ab_frame", 32'(frame_idx), 0);
    check("ab_rep", 32'(rep_count), 0);
    check("ab_done", 32'(done), 0);
    check("ab_busy", 32'(busy), 0);

    // Abort and start together in IDLE.
    rep_target = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    tick_update();
    check("as_phase", 32'(phase), 0);
    check("as_busy", 32'(busy), 0);
    tick_update();
    check("as_phase_later", 32'(phase), 0);

`ifdef SQUAT_PAUSE_EN
    // Pause five ticks in ASCEND at frame 2, then finish the rep unchanged.
    pulse_start(8'd1);
    repeat (12) tick_update();
    check("pz_pre_frame", 32'(frame_idx), 2);
    check("pz_pre_phase", 32'(phase), 3);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick_update();
      check($sformatf("pz_frame_k%0d", k), 32'(frame_idx), 2);
      check($sformatf("pz_phase_k%0d", k), 32'(phase), 3);
    end
    pause = 1'b0;
    for (int t = 12; t < 16; t++) begin
      tick_update();
      check($sformatf("pz_frame_t%0d", t), 32'(frame_idx), exp_f[t]);
      check($sformatf("pz_done_t%0d", t), 32'(done), (t == 15) ? 1 : 0);
    end
`endif

    // Asynchronous reset mid-DESCEND.
    pulse_start(8'd1);
    repeat (3) tick_update();
    check("rs_pre_frame", 32'(frame_idx), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rs_phase", 32'(phase), 0);
    check("rs_frame", 32'(frame_idx), 0);
    check("rs_rep", 32'(rep_count), 0);
    check("rs_busy", 32'(busy), 0);
    check("rs_done", 32'(done), 0);
    check("rs_tick", 32'(frame_tick), 0);
    prev_frame = frame_idx;
    cyc();
    reset = 1'b0;
    tick_update();
    check("rs_post_phase", 32'(phase), 0);
    check("rs_post_done", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
